// File: rtl/oh_memory_bist_if.sv
// Bus between the march-test engine and its memory / test controller.
// master = BIST engine, slave = memory wrapper plus controller.
interface oh_memory_bist_if #(
    parameter int unsigned DW = 104,
    parameter int unsigned AW = 5
);
    logic          start;
    logic [DW-1:0] pattern;
    logic          bist_en;
    logic          bist_we;
    logic [DW-1:0] bist_wem;
    logic [AW-1:0] bist_addr;
    logic [DW-1:0] bist_din;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_dout;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;

    modport master (
        input  start, pattern, rd_dout,
        output bist_en, bist_we, bist_wem, bist_addr, bist_din, rd_en, rd_addr,
               busy, done, fail, fail_addr
    );

    modport slave (
        output start, pattern, rd_dout,
        input  bist_en, bist_we, bist_wem, bist_addr, bist_din, rd_en, rd_addr,
               busy, done, fail, fail_addr
    );
endinterface

// File: rtl/oh_memory_bist.sv
// Four-element march engine (W, R/~W, descending R/W, R) for a dual-port memory.
// Reports sticky fail and the first failing address; done is a level until the next start.
module oh_memory_bist #(
    parameter int unsigned DW    = 104,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned RL    = 1,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               nreset,
    oh_memory_bist_if.master   bus
);
    typedef enum logic [2:0] {StIdle, StE0, StE1, StE2, StE3, StDrain, StDone} state_e;

    localparam logic [AW-1:0] LastAddr  = AW'(DEPTH - 1);
    localparam logic [2:0]    LastDrain = 3'(RL - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;
    logic [2:0]    drain_q, drain_d;
    logic          accept, last;

    logic [DW-1:0] pat_q;
    logic          busy_q, done_q, fail_q;
    logic [AW-1:0] fail_addr_q;

    logic          we_d, re_d;
    logic [DW-1:0] din_d, exp_d;
    logic          we_q, re_q;
    logic [DW-1:0] wem_q, din_q, exp_q;
    logic [AW-1:0] waddr_q, raddr_q;

    logic [RL-1:0] pv_q;
    logic [AW-1:0] pa_q [RL];
    logic [DW-1:0] pe_q [RL];
    logic          miscompare;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            phase_q <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
        end
    end

    // Addresses wrap by explicit compare so non-power-of-2 depths stay in range.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        drain_d = drain_q;
        accept  = bus.start && !busy_q && (state_q == StIdle || state_q == StDone);
        last    = (addr_q == LastAddr);
        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = StE0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            StE0: begin
                if (last) begin
                    state_d = StE1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            StE1: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    if (last) begin
                        state_d = StE2;
                        addr_d  = LastAddr;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            StE2: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    if (addr_q == '0) begin
                        state_d = StE3;
                    end else begin
                        addr_d = addr_q - AW'(1);
                    end
                end
            end
            StE3: begin
                if (last) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        we_d  = 1'b0;
        re_d  = 1'b0;
        din_d = pat_q;
        exp_d = pat_q;
        case (state_q)
            StE0: we_d = 1'b1;
            StE1: begin
                we_d  = phase_q;
                re_d  = !phase_q;
                din_d = ~pat_q;
            end
            StE2: begin
                we_d  = phase_q;
                re_d  = !phase_q;
                exp_d = ~pat_q;
            end
            StE3:    re_d = 1'b1;
            default: ;
        endcase
    end

    // Memory-side outputs are registered from the current state; addresses hold when idle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wem_q   <= '0;
            din_q   <= '0;
            exp_q   <= '0;
            waddr_q <= '0;
            raddr_q <= '0;
        end else begin
            we_q  <= we_d;
            re_q  <= re_d;
            wem_q <= we_d ? '1 : '0;
            if (we_d) begin
                waddr_q <= addr_q;
                din_q   <= din_d;
            end
            if (re_d) begin
                raddr_q <= addr_q;
                exp_q   <= exp_d;
            end
        end
    end

    // Each read issued to the memory carries its address/expected value down an RL-deep pipe.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pv_q <= '0;
            for (int i = 0; i < int'(RL); i++) begin
                pa_q[i] <= '0;
                pe_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= re_q;
            pa_q[0] <= raddr_q;
            pe_q[0] <= exp_q;
            for (int i = 1; i < int'(RL); i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    assign miscompare = pv_q[RL-1] && (bus.rd_dout != pe_q[RL-1]);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else if (accept) begin
            pat_q       <= bus.pattern;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            if (state_q == StDone && busy_q) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (miscompare) begin
                fail_q <= 1'b1;
                if (!fail_q) fail_addr_q <= pa_q[RL-1];
            end
        end
    end

    assign bus.bist_en   = busy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.bist_we   = we_q;
    assign bus.bist_wem  = wem_q;
    assign bus.bist_addr = waddr_q;
    assign bus.bist_din  = din_q;
    assign bus.rd_en     = re_q;
    assign bus.rd_addr   = raddr_q;
endmodule

// File: tb/tb_oh_memory_bist.sv
// Bench for oh_memory_bist: two engines (DEPTH=4/RL=1 and DEPTH=5/RL=3) with memory models,
// a scoreboard of expected write/read sequences and per-run results.
module tb_oh_memory_bist;
    logic       clk = 1'b0;
    logic       nreset;
    logic       start;
    logic [7:0] pattern;
    logic       sel;
    logic       mon_on;
    int         fault;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    oh_memory_bist_if #(.DW(8), .AW(2)) ifa ();
    oh_memory_bist_if #(.DW(8), .AW(3)) ifb ();

    oh_memory_bist #(.DW(8), .DEPTH(4), .RL(1)) dut_a (.clk(clk), .nreset(nreset), .bus(ifa));
    oh_memory_bist #(.DW(8), .DEPTH(5), .RL(3)) dut_b (.clk(clk), .nreset(nreset), .bus(ifb));

    assign ifa.start   = start & ~sel;
    assign ifb.start   = start & sel;
    assign ifa.pattern = pattern;
    assign ifb.pattern = pattern;

    // Memory A: fault 1 = bit 3 of addr 2 reads as 0, fault 2 = write to addr 1 flips addr 0 bit 0.
    logic [7:0] mem_a [4];
    logic [7:0] rdq_a;
    always @(posedge clk) begin
        if (ifa.bist_we) begin
            mem_a[ifa.bist_addr] <= (mem_a[ifa.bist_addr] & ~ifa.bist_wem) |
                                    (ifa.bist_din & ifa.bist_wem);
            if (fault == 2 && ifa.bist_addr == 2'd1) mem_a[0][0] <= ~mem_a[0][0];
        end
        if (ifa.rd_en)
            rdq_a <= mem_a[ifa.rd_addr] & ~((fault == 1 && ifa.rd_addr == 2'd2) ? 8'h08 : 8'h00);
    end
    assign ifa.rd_dout = rdq_a;

    logic [7:0] mem_b [5];
    logic [7:0] rdp_b [3];
    always @(posedge clk) begin
        if (ifb.bist_we)
            mem_b[ifb.bist_addr] <= (mem_b[ifb.bist_addr] & ~ifb.bist_wem) |
                                    (ifb.bist_din & ifb.bist_wem);
        if (ifb.rd_en) rdp_b[0] <= mem_b[ifb.rd_addr];
        rdp_b[1] <= rdp_b[0];
        rdp_b[2] <= rdp_b[1];
    end
    assign ifb.rd_dout = rdp_b[2];

    logic       m_we, m_re, m_done, m_fail, m_busy, m_en;
    logic [7:0] m_waddr, m_raddr, m_din, m_wem, m_fa;
    always_comb begin
        if (sel) begin
            m_we = ifb.bist_we; m_re = ifb.rd_en; m_done = ifb.done; m_fail = ifb.fail;
            m_busy = ifb.busy; m_en = ifb.bist_en; m_waddr = 8'(ifb.bist_addr);
            m_raddr = 8'(ifb.rd_addr); m_din = ifb.bist_din; m_wem = ifb.bist_wem;
            m_fa = 8'(ifb.fail_addr);
        end else begin
            m_we = ifa.bist_we; m_re = ifa.rd_en; m_done = ifa.done; m_fail = ifa.fail;
            m_busy = ifa.busy; m_en = ifa.bist_en; m_waddr = 8'(ifa.bist_addr);
            m_raddr = 8'(ifa.rd_addr); m_din = ifa.bist_din; m_wem = ifa.bist_wem;
            m_fa = 8'(ifa.fail_addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    logic [63:0] res_q[$];

    task automatic load_exp(input int depth, input logic [7:0] p);
        wq.delete();
        rq.delete();
        for (int a = 0; a < depth; a++) wq.push_back({8'(a), p});
        for (int a = 0; a < depth; a++) begin
            rq.push_back(8'(a));
            wq.push_back({8'(a), ~p});
        end
        for (int a = depth - 1; a >= 0; a--) begin
            rq.push_back(8'(a));
            wq.push_back({8'(a), p});
        end
        for (int a = 0; a < depth; a++) rq.push_back(8'(a));
    endtask

    always @(negedge clk) begin
        if (mon_on && (m_we || m_re)) begin
            chk("rd_wr_exclusive", {m_we, m_re} != 2'b11, 1);
            if (m_we) begin
                chk("wr_pending", wq.size() != 0, 1);
                if (wq.size() != 0) chk("wr_seq", {m_waddr, m_din, m_wem}, {wq.pop_front(), 8'hFF});
            end
            if (m_re) begin
                chk("rd_pending", rq.size() != 0, 1);
                if (rq.size() != 0) chk("rd_seq", m_raddr, rq.pop_front());
            end
        end
    end

    task automatic run(input logic s, input logic [7:0] p, input int depth, input int exp_edges,
                       input logic exp_fail, input int exp_fa, input int repulse);
        int          n;
        logic [63:0] e;
        sel = s;
        load_exp(depth, p);
        res_q.push_back({32'(exp_edges), 8'(exp_fail), 8'(exp_fa), 16'h0});
        mon_on = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        pattern = p;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", {m_busy, m_done, m_fail, m_fa}, {1'b1, 1'b0, 1'b0, 8'h00});
        n = 0;
        while (n < 400 && !m_done) begin
            if (n + 1 == repulse) begin
                start   = 1'b1;
                pattern = ~p;
            end
            @(posedge clk);
            #1 start = 1'b0;
            n++;
        end
        mon_on = 1'b0;
        e = res_q.pop_front();
        chk("done_edge", 32'(n), e[63:32]);
        chk("fail", m_fail, e[31:24]);
        chk("fail_addr", m_fa, e[23:16]);
        chk("idle_after_done", {m_busy, m_en}, 2'b00);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
    endtask

    initial begin
        nreset  = 1'b0;
        start   = 1'b0;
        pattern = 8'h00;
        sel     = 1'b0;
        mon_on  = 1'b0;
        fault   = 0;
        #23;
        chk("reset_a", {ifa.busy, ifa.done, ifa.fail, ifa.fail_addr, ifa.bist_en, ifa.bist_we,
                        ifa.rd_en, ifa.bist_addr, ifa.rd_addr, ifa.bist_din, ifa.bist_wem}, 0);
        chk("reset_b", {ifb.busy, ifb.done, ifb.fail, ifb.bist_en, ifb.bist_we, ifb.rd_en}, 0);
        @(negedge clk) nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_after_reset", {m_busy, m_done, m_en}, 3'b000);

        run(1'b0, 8'hA5, 4, 26, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("mem_end%0d", i), mem_a[i], 8'hA5);

        fault = 1;
        run(1'b0, 8'hFF, 4, 26, 1'b1, 2, 0);
        fault = 2;
        run(1'b0, 8'hA5, 4, 26, 1'b1, 0, 0);
        fault = 0;
        // Restart right after a failing run, with an ignored start pulse at edge 10.
        run(1'b0, 8'h3C, 4, 26, 1'b0, 0, 10);

        sel = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        pattern = 8'h5A;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #2 nreset = 1'b0;
        #1 chk("abort_outputs", {ifa.busy, ifa.done, ifa.fail, ifa.fail_addr, ifa.bist_en,
                                 ifa.bist_we, ifa.rd_en, ifa.bist_addr, ifa.rd_addr,
                                 ifa.bist_din, ifa.bist_wem}, 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_after_abort", {m_busy, m_done, m_en, m_we, m_re}, 5'b00000);

        run(1'b1, 8'h00, 5, 34, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
